tomasulo_issue_ctrl: RTL and testbench
======================================

// Module: tomasulo_issue_ctrl
// PURPOSE
//  Parametrised Tomasulo issue stage. Sits between decode and the reservation stations (RS).
//  Each instruction gets a ROB entry and an RS slot of its class (ALU/MUL/BCH).
//  A register alias table (RAT) supplies source tags; a full ROB or full target RS stalls decode.
//  Tracks ROB head/tail/count; retires on commit and clears everything on flush.
// PARAMETERS
//  ROB_DEPTH  8   ROB entries, >=2, any integer (wrap by compare, not masking)
//  RS_DEPTH   3   slots per RS class
//  NUM_REGS   16  architectural registers
//  REG_W      4   register index width
//  ADDR_W     8   immediate/address field width
//  TAG_W      $clog2(ROB_DEPTH)  derived localparam
// PORTS
//  clk1          in   1         clock, all state on posedge
//  reset         in   1         synchronous, active-high
//  in_valid      in   1         decoded instruction present
//  in_ready      out  1         issue accepted this cycle when in_valid&&in_ready
//  in_func       in   4         opcode; class via pkg func_to_class
//  in_rs1/in_rs2 in   REG_W     source registers
//  in_rd         in   REG_W     destination register
//  in_addr       in   ADDR_W    immediate/address
//  rs_release    in   3         one-hot per class: one RS slot freed this cycle
//  commit_valid  in   1         retire ROB head
//  flush         in   1         discard all in-flight state
//  iss_valid     out  1         registered issue pulse to RS
//  iss_class     out  3         one-hot target RS
//  iss_tag       out  TAG_W     allocated ROB tag
//  iss_rs1_busy, iss_rs2_busy out 1; iss_rs1_tag, iss_rs2_tag out TAG_W  RAT lookups
//  iss_rd, iss_func, iss_addr out REG_W/4/ADDR_W  forwarded fields
//  rob_head_tag  out  TAG_W     tag of oldest entry
//  rob_count     out  TAG_W+1   occupied ROB entries
//  stall_cause   out  2         00 none, 01 ROB full, 10 RS full (ROB wins if both)
// BEHAVIOUR
//  - Reset or flush (same effect, reset higher priority): head=tail=count=0; RS counters=0;
//    all RAT busy=0; every output register 0. Inputs ignored that cycle; in_ready=0.
//  - in_ready comb. from registered state + in_func: count<ROB_DEPTH && rs_cnt[cls]<RS_DEPTH.
//    No bypass: same-cycle commit or rs_release does not raise in_ready.
//  - Issue fire: tail advances (ROB_DEPTH-1 -> 0); rob_rd[tail]<=in_rd;
//    rs_cnt[cls]++; RAT[in_rd]<={busy=1, tag=tail}.
//  - iss_* registered, 1-cycle latency; iss_valid high exactly one cycle per fire.
//  - Sources read RAT before the same-cycle rd update (rs1==rd reports the older mapping).
//  - No commit bypass: source matching a same-cycle commit is still reported busy with old tag.
//  - Commit when count>0: head advances with wrap; RAT[rob_rd[head]].busy cleared only if
//    its tag == head. Issue to the same rd in the same cycle wins (busy stays, new tag).
//  - commit_valid with count==0: ignored, no state change.
//  - Issue+commit same cycle: count unchanged; head and tail both advance.
//  - Issue+release same class: rs_cnt unchanged. rs_release at cnt 0 ignored (saturate).
//  - No fire: stall_cause reflects the blocking reason whenever in_valid=1, else 00.
// STRUCTURE
//  - tomasulo_pkg: CLS_ALU=0/CLS_MUL=1/CLS_BCH=2, NUM_CLASS=3, func_to_class()
//    (4'h0-7 ALU, 8-B MUL, C-F BCH), stall_cause encodings.
//  - Sub-module issue_rat: NUM_REGS x {busy,tag}; 2 read ports, 1 issue write,
//    1 tag-matched commit clear, sync clear.
//  - Top holds ROB pointers/count, rob_rd array, RS counters, output registers.
// TESTING
//  1. Reset, then 8 ALU/MUL/BCH mixed issues, no commit -> tags 0..7, rob_count=8, in_ready=0, stall_cause=01.
//  2. 3 MUL issues, 4th MUL (in_func=8) -> in_ready=0, stall_cause=10; ALU (func 0) still accepted; rs_release=3'b010 -> MUL accepted next cycle.
//  3. ROB full, commit_valid=1 with in_valid=1 -> no issue that cycle; next cycle issue gets tag 0 (wrap), head=1.
//  4. Issue r3<-.. (tag 2), then rs1=r3 -> iss_rs1_busy=1, tag=2; commit tag 2 -> later rs1=r3 reports busy=0.
//  5. Issue rd=r5 same cycle as commit of old r5 producer -> RAT[r5] stays busy with new tag.
//  6. Flush mid-stream at count=5 -> next cycle count=0, all sources busy=0, iss_valid=0; commit when empty ignored.

Source files
------------

// File: rtl/tomasulo_issue_ctrl_pkg.sv
// Shared definitions for the Tomasulo issue stage: RS class indices, stall
// encodings and the opcode-to-class decode.
package tomasulo_pkg;

  localparam int CLS_ALU   = 0;
  localparam int CLS_MUL   = 1;
  localparam int CLS_BCH   = 2;
  localparam int NUM_CLASS = 3;

  typedef logic [1:0] cls_idx_t;

  typedef enum logic [1:0] {
    STALL_NONE = 2'b00,
    STALL_ROB  = 2'b01,
    STALL_RS   = 2'b10
  } stall_cause_e;

  // 4'h0-7 ALU, 4'h8-B MUL, 4'hC-F BCH
  function automatic cls_idx_t func_to_class(input logic [3:0] func);
    if (!func[3])      return cls_idx_t'(CLS_ALU);
    else if (!func[2]) return cls_idx_t'(CLS_MUL);
    else               return cls_idx_t'(CLS_BCH);
  endfunction

endpackage

// File: rtl/tomasulo_issue_ctrl_rat.sv
// Register alias table: per architectural register a busy bit and the ROB tag
// of its youngest in-flight producer. Two read ports, one issue write, one commit clear.
module issue_rat
  import tomasulo_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int REG_W    = 4,
  parameter int TAG_W    = 3
) (
  input  logic             clk1,
  input  logic             clear,
  input  logic [REG_W-1:0] rd1_idx,
  input  logic [REG_W-1:0] rd2_idx,
  output logic             rd1_busy,
  output logic [TAG_W-1:0] rd1_tag,
  output logic             rd2_busy,
  output logic [TAG_W-1:0] rd2_tag,
  input  logic             wr_en,
  input  logic [REG_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic             cm_en,
  input  logic [REG_W-1:0] cm_idx,
  input  logic [TAG_W-1:0] cm_tag
);

  logic             busy [NUM_REGS];
  logic [TAG_W-1:0] tag  [NUM_REGS];

  // Reads see the table before this cycle's write, so a source equal to the
  // destination reports the older producer.
  assign rd1_busy = busy[rd1_idx];
  assign rd1_tag  = tag[rd1_idx];
  assign rd2_busy = busy[rd2_idx];
  assign rd2_tag  = tag[rd2_idx];

  always_ff @(posedge clk1) begin
    if (clear) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        busy[r] <= 1'b0;
        tag[r]  <= '0;
      end
    end else begin
      // Only the producer the table still points at may release the register.
      if (cm_en && (tag[cm_idx] == cm_tag))
        busy[cm_idx] <= 1'b0;
      // NOTE: non-blocking assignments to the same element resolve to the last
      // one executed, so a same-cycle issue to this register overrides the clear.
      if (wr_en) begin
        busy[wr_idx] <= 1'b1;
        tag[wr_idx]  <= wr_tag;
      end
    end
  end

endmodule

// File: rtl/tomasulo_issue_ctrl.sv
// Tomasulo issue stage: allocates a ROB entry and an RS slot per decoded
// instruction, looks up source tags in the RAT and forwards a registered issue packet.
module tomasulo_issue_ctrl
  import tomasulo_pkg::*;
#(
  parameter  int ROB_DEPTH = 8,
  parameter  int RS_DEPTH  = 3,
  parameter  int NUM_REGS  = 16,
  parameter  int REG_W     = 4,
  parameter  int ADDR_W    = 8,
  localparam int TAG_W     = $clog2(ROB_DEPTH)
) (
  input  logic              clk1,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_func,
  input  logic [REG_W-1:0]  in_rs1,
  input  logic [REG_W-1:0]  in_rs2,
  input  logic [REG_W-1:0]  in_rd,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [2:0]        rs_release,
  input  logic              commit_valid,
  input  logic              flush,
  output logic              iss_valid,
  output logic [2:0]        iss_class,
  output logic [TAG_W-1:0]  iss_tag,
  output logic              iss_rs1_busy,
  output logic [TAG_W-1:0]  iss_rs1_tag,
  output logic              iss_rs2_busy,
  output logic [TAG_W-1:0]  iss_rs2_tag,
  output logic [REG_W-1:0]  iss_rd,
  output logic [3:0]        iss_func,
  output logic [ADDR_W-1:0] iss_addr,
  output logic [TAG_W-1:0]  rob_head_tag,
  output logic [TAG_W:0]    rob_count,
  output logic [1:0]        stall_cause
);

  localparam int               CNT_W    = $clog2(RS_DEPTH + 1);
  localparam logic [TAG_W-1:0] LAST_TAG = TAG_W'(ROB_DEPTH - 1);

  logic [TAG_W-1:0] head, tail;
  logic [TAG_W:0]   count;
  logic [REG_W-1:0] rob_rd [ROB_DEPTH];
  logic [CNT_W-1:0] rs_cnt [NUM_CLASS];

  cls_idx_t         cls;
  logic             kill, rob_ok, rs_ok, fire, retire;
  logic             rat_rs1_busy, rat_rs2_busy;
  logic [TAG_W-1:0] rat_rs1_tag, rat_rs2_tag;

  // ROB depth need not be a power of two, so pointers wrap by compare.
  function automatic logic [TAG_W-1:0] next_ptr(input logic [TAG_W-1:0] p);
    return (p == LAST_TAG) ? '0 : p + TAG_W'(1);
  endfunction

  // Readiness depends only on registered occupancy: frees arriving this cycle
  // are not bypassed into in_ready.
  always_comb begin
    cls    = func_to_class(in_func);
    kill   = reset || flush;
    rob_ok = (count < (TAG_W+1)'(ROB_DEPTH));
    rs_ok  = 1'b0;
    for (int c = 0; c < NUM_CLASS; c++)
      if (cls == cls_idx_t'(c))
        rs_ok = (rs_cnt[c] < CNT_W'(RS_DEPTH));
    in_ready = !kill && rob_ok && rs_ok;
    fire     = in_valid && in_ready;
    retire   = commit_valid && (count != '0) && !kill;

    stall_cause = STALL_NONE;
    if (in_valid && !fire && !kill) begin
      if (!rob_ok)     stall_cause = STALL_ROB;
      else if (!rs_ok) stall_cause = STALL_RS;
    end
  end

  always_ff @(posedge clk1) begin
    if (kill) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (fire)   tail <= next_ptr(tail);
      if (retire) head <= next_ptr(head);
      if (fire && !retire)      count <= count + (TAG_W+1)'(1);
      else if (retire && !fire) count <= count - (TAG_W+1)'(1);
    end
  end

  // NOTE: the destination array is deliberately left out of reset; an entry is
  // only read after an issue has written it, so clearing it would buy nothing.
  always_ff @(posedge clk1) begin
    if (fire) rob_rd[tail] <= in_rd;
  end

  // A release against an empty class is dropped rather than wrapping.
  always_ff @(posedge clk1) begin
    if (kill) begin
      for (int c = 0; c < NUM_CLASS; c++) rs_cnt[c] <= '0;
    end else begin
      for (int c = 0; c < NUM_CLASS; c++) begin
        if (fire && (cls == cls_idx_t'(c)) && !(rs_release[c] && (rs_cnt[c] != '0)))
          rs_cnt[c] <= rs_cnt[c] + CNT_W'(1);
        else if (!(fire && (cls == cls_idx_t'(c))) && rs_release[c] && (rs_cnt[c] != '0))
          rs_cnt[c] <= rs_cnt[c] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk1) begin
    if (kill) begin
      iss_valid    <= 1'b0;
      iss_class    <= '0;
      iss_tag      <= '0;
      iss_rs1_busy <= 1'b0;
      iss_rs1_tag  <= '0;
      iss_rs2_busy <= 1'b0;
      iss_rs2_tag  <= '0;
      iss_rd       <= '0;
      iss_func     <= '0;
      iss_addr     <= '0;
    end else begin
      iss_valid <= fire;
      if (fire) begin
        iss_class    <= 3'b001 << cls;
        iss_tag      <= tail;
        iss_rs1_busy <= rat_rs1_busy;
        iss_rs1_tag  <= rat_rs1_tag;
        iss_rs2_busy <= rat_rs2_busy;
        iss_rs2_tag  <= rat_rs2_tag;
        iss_rd       <= in_rd;
        iss_func     <= in_func;
        iss_addr     <= in_addr;
      end
    end
  end

  assign rob_head_tag = head;
  assign rob_count    = count;

  issue_rat #(
    .NUM_REGS (NUM_REGS),
    .REG_W    (REG_W),
    .TAG_W    (TAG_W)
  ) u_rat (
    .clk1     (clk1),
    .clear    (kill),
    .rd1_idx  (in_rs1),
    .rd2_idx  (in_rs2),
    .rd1_busy (rat_rs1_busy),
    .rd1_tag  (rat_rs1_tag),
    .rd2_busy (rat_rs2_busy),
    .rd2_tag  (rat_rs2_tag),
    .wr_en    (fire),
    .wr_idx   (in_rd),
    .wr_tag   (tail),
    .cm_en    (retire),
    .cm_idx   (rob_rd[head]),
    .cm_tag   (head)
  );

endmodule

// File: tb/tb_tomasulo_issue_ctrl.sv
// Directed bench for tomasulo_issue_ctrl with hand-computed expectations
// for allocation, stalls, RAT tracking, commit and flush.
module tb_tomasulo_issue_ctrl;

  logic       clk1 = 1'b0;
  logic       reset, in_valid, commit_valid, flush;
  logic [3:0] in_func, in_rs1, in_rs2, in_rd;
  logic [7:0] in_addr;
  logic [2:0] rs_release;
  logic       in_ready, iss_valid, iss_rs1_busy, iss_rs2_busy;
  logic [2:0] iss_class, iss_tag, iss_rs1_tag, iss_rs2_tag, rob_head_tag;
  logic [3:0] iss_rd, iss_func, rob_count;
  logic [7:0] iss_addr;
  logic [1:0] stall_cause;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk1 = ~clk1;

  tomasulo_issue_ctrl dut (
    .clk1(clk1), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_func(in_func), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_addr(in_addr), .rs_release(rs_release), .commit_valid(commit_valid),
    .flush(flush), .iss_valid(iss_valid), .iss_class(iss_class), .iss_tag(iss_tag),
    .iss_rs1_busy(iss_rs1_busy), .iss_rs1_tag(iss_rs1_tag),
    .iss_rs2_busy(iss_rs2_busy), .iss_rs2_tag(iss_rs2_tag), .iss_rd(iss_rd),
    .iss_func(iss_func), .iss_addr(iss_addr), .rob_head_tag(rob_head_tag),
    .rob_count(rob_count), .stall_cause(stall_cause)
  );

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] f, input logic [3:0] r1,
                       input logic [3:0] r2, input logic [3:0] rd, input logic cm,
                       input logic [2:0] rel);
    in_valid = v; in_func = f; in_rs1 = r1; in_rs2 = r2; in_rd = rd;
    in_addr = {rd, f}; commit_valid = cm; rs_release = rel;
  endtask

  task automatic step(input logic v, input logic [3:0] f, input logic [3:0] r1,
                      input logic [3:0] r2, input logic [3:0] rd, input logic cm,
                      input logic [2:0] rel);
    drive(v, f, r1, r2, rd, cm, rel);
    tick();
    drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 3'b000);
  endtask

  task automatic do_reset();
    reset = 1'b1; flush = 1'b0;
    drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 3'b000);
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0;
    drive(1'b1, 4'h0, 4'h0, 4'h0, 4'h1, 1'b0, 3'b000);
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready_held: got %b want 0", in_ready); end
    tick(); tick();
    reset = 1'b0;
    drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 3'b000);
    #1;
    n_cmp++; if ({iss_valid, rob_count, rob_head_tag, stall_cause} !== 10'b0)
      begin n_bad++; $display("FAIL reset_state: got v=%b cnt=%0d head=%0d stall=%b want all 0", iss_valid, rob_count, rob_head_tag, stall_cause); end
    in_valid = 1'b1;
    #1;
    n_cmp++; if ({in_ready, stall_cause} !== 3'b100) begin n_bad++; $display("FAIL reset_ready_after: got rdy=%b stall=%b want 1/00", in_ready, stall_cause); end
    in_valid = 1'b0;
  endtask

  // Eight mixed issues: rs1 points at the previous rd, rs2 equals own rd.
  task automatic test_fill();
    logic [3:0]  funcs   [8] = '{4'h0, 4'h8, 4'hC, 4'h1, 4'h9, 4'hD, 4'h2, 4'hA};
    logic [2:0]  classes [8] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
    logic [15:0] got, exp;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, funcs[i], 4'(i), 4'(i + 1), 4'(i + 1), 1'b0, 3'b000);
      got = {iss_valid, iss_class, iss_tag, iss_rs1_busy, iss_rs1_tag, iss_rs2_busy, iss_rd};
      exp = {1'b1, classes[i], 3'(i), (i > 0), (i > 0) ? 3'(i - 1) : 3'd0, 1'b0, 4'(i + 1)};
      n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL fill_issue%0d: got %h want %h", i, got, exp); end
    end
    n_cmp++; if ({iss_func, iss_addr} !== 12'hA_8A) begin n_bad++; $display("FAIL fill_fields: got %h want A8A", {iss_func, iss_addr}); end
    drive(1'b1, 4'hE, 4'h0, 4'h0, 4'h9, 1'b0, 3'b000);
    #1;
    n_cmp++; if ({rob_count, in_ready, stall_cause} !== 7'b1000_0_01)
      begin n_bad++; $display("FAIL fill_rob_full: got cnt=%0d rdy=%b stall=%b want 8/0/01", rob_count, in_ready, stall_cause); end
    in_func = 4'h0;
    #1;
    n_cmp++; if (stall_cause !== 2'b01) begin n_bad++; $display("FAIL fill_both_full: got %b want 01", stall_cause); end
    tick();
    n_cmp++; if (iss_valid !== 1'b0) begin n_bad++; $display("FAIL fill_pulse: got %b want 0", iss_valid); end
  endtask

  // Continues from a full ROB with head=tail=0.
  task automatic test_rob_wrap();
    drive(1'b1, 4'hE, 4'h0, 4'h0, 4'h9, 1'b1, 3'b000);
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL wrap_no_bypass: got %b want 0", in_ready); end
    tick();
    drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 3'b000);
    n_cmp++; if ({iss_valid, rob_count, rob_head_tag} !== 8'b0_0111_001)
      begin n_bad++; $display("FAIL wrap_commit: got v=%b cnt=%0d head=%0d want 0/7/1", iss_valid, rob_count, rob_head_tag); end
    step(1'b1, 4'hE, 4'h1, 4'h0, 4'h9, 1'b0, 3'b000);
    n_cmp++; if ({iss_valid, iss_tag, rob_head_tag, rob_count, iss_rs1_busy} !== 12'b1_000_001_1000_0)
      begin n_bad++; $display("FAIL wrap_issue: got v=%b tag=%0d head=%0d cnt=%0d rs1b=%b want 1/0/1/8/0", iss_valid, iss_tag, rob_head_tag, rob_count, iss_rs1_busy); end
  endtask

  task automatic test_rs_full();
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 4'(8 + i), 4'h0, 4'h0, 4'(i + 1), 1'b0, 3'b000);
    drive(1'b1, 4'h8, 4'h0, 4'h0, 4'h4, 1'b0, 3'b000);
    #1;
    n_cmp++; if ({in_ready, stall_cause} !== 3'b0_10) begin n_bad++; $display("FAIL rs_mul_full: got rdy=%b stall=%b want 0/10", in_ready, stall_cause); end
    in_func = 4'h0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rs_alu_ready: got %b want 1", in_ready); end
    tick();
    n_cmp++; if ({iss_valid, iss_tag, iss_class} !== 7'b1_011_001) begin n_bad++; $display("FAIL rs_alu_issue: got tag=%0d cls=%b want 3/001", iss_tag, iss_class); end
    drive(1'b1, 4'h8, 4'h0, 4'h0, 4'h5, 1'b0, 3'b010);
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rs_release_no_bypass: got %b want 0", in_ready); end
    tick();
    drive(1'b1, 4'h8, 4'h0, 4'h0, 4'h5, 1'b0, 3'b000);
    n_cmp++; if ({iss_valid, in_ready} !== 2'b01) begin n_bad++; $display("FAIL rs_release_next: got v=%b rdy=%b want 0/1", iss_valid, in_ready); end
    tick();
    drive(1'b1, 4'h9, 4'h0, 4'h0, 4'h6, 1'b0, 3'b000);
    n_cmp++; if ({iss_valid, iss_tag, iss_class, stall_cause} !== 9'b1_100_010_10)
      begin n_bad++; $display("FAIL rs_mul_reissue: got v=%b tag=%0d cls=%b stall=%b want 1/4/010/10", iss_valid, iss_tag, iss_class, stall_cause); end
    step(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 3'b100);
    for (int i = 0; i < 3; i++) step(1'b1, 4'(12 + i), 4'h0, 4'h0, 4'(7 + i), 1'b0, 3'b000);
    n_cmp++; if ({iss_valid, iss_tag, iss_class, rob_count} !== 11'b1_111_100_1000)
      begin n_bad++; $display("FAIL rs_release_saturate: got v=%b tag=%0d cls=%b cnt=%0d want 1/7/100/8", iss_valid, iss_tag, iss_class, rob_count); end
    step(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 3'b000);
    drive(1'b1, 4'hF, 4'h0, 4'h0, 4'hA, 1'b0, 3'b000);
    #1;
    n_cmp++; if ({rob_count, in_ready, stall_cause} !== 7'b0111_0_10)
      begin n_bad++; $display("FAIL rs_bch_full: got cnt=%0d rdy=%b stall=%b want 7/0/10", rob_count, in_ready, stall_cause); end
    in_valid = 1'b0;
  endtask

  task automatic test_rat_commit();
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 4'(i), 4'h0, 4'h0, 4'(i + 1), 1'b0, 3'b000);
    step(1'b1, 4'h8, 4'h3, 4'h0, 4'h4, 1'b0, 3'b000);
    n_cmp++; if ({iss_rs1_busy, iss_rs1_tag, iss_tag} !== 7'b1_010_011)
      begin n_bad++; $display("FAIL rat_rs1_busy: got b=%b t=%0d tag=%0d want 1/2/3", iss_rs1_busy, iss_rs1_tag, iss_tag); end
    for (int i = 0; i < 3; i++) step(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 3'b000);
    n_cmp++; if ({rob_head_tag, rob_count} !== 7'b011_0001) begin n_bad++; $display("FAIL rat_commit_ptrs: got head=%0d cnt=%0d want 3/1", rob_head_tag, rob_count); end
    step(1'b1, 4'h9, 4'h3, 4'h4, 4'h6, 1'b0, 3'b000);
    n_cmp++; if ({iss_rs1_busy, iss_rs2_busy, iss_rs2_tag, iss_tag} !== 8'b0_1_011_100)
      begin n_bad++; $display("FAIL rat_after_commit: got b1=%b b2=%b t2=%0d tag=%0d want 0/1/3/4", iss_rs1_busy, iss_rs2_busy, iss_rs2_tag, iss_tag); end
  endtask

  task automatic test_same_rd();
    do_reset();
    step(1'b1, 4'h0, 4'h0, 4'h0, 4'h5, 1'b0, 3'b000);
    step(1'b1, 4'h1, 4'h0, 4'h0, 4'h5, 1'b1, 3'b000);
    n_cmp++; if ({iss_tag, rob_head_tag, rob_count} !== 10'b001_001_0001)
      begin n_bad++; $display("FAIL same_rd_ptrs: got tag=%0d head=%0d cnt=%0d want 1/1/1", iss_tag, rob_head_tag, rob_count); end
    step(1'b1, 4'h2, 4'h5, 4'h0, 4'h7, 1'b1, 3'b000);
    n_cmp++; if ({iss_rs1_busy, iss_rs1_tag} !== 4'b1_001) begin n_bad++; $display("FAIL same_rd_new_tag: got b=%b t=%0d want 1/1", iss_rs1_busy, iss_rs1_tag); end
    step(1'b1, 4'h8, 4'h5, 4'h0, 4'h8, 1'b0, 3'b000);
    n_cmp++; if ({iss_rs1_busy, iss_tag} !== 4'b0_011) begin n_bad++; $display("FAIL same_rd_cleared: got b=%b tag=%0d want 0/3", iss_rs1_busy, iss_tag); end
  endtask

  task automatic test_flush();
    logic [3:0] funcs [5] = '{4'h0, 4'h8, 4'hC, 4'h1, 4'h9};
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, funcs[i], 4'h0, 4'h0, 4'(i + 1), 1'b0, 3'b000);
    n_cmp++; if (rob_count !== 4'd5) begin n_bad++; $display("FAIL flush_pre_count: got %0d want 5", rob_count); end
    drive(1'b1, 4'h0, 4'h0, 4'h0, 4'h6, 1'b0, 3'b000);
    flush = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL flush_ready: got %b want 0", in_ready); end
    tick();
    flush = 1'b0;
    drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 3'b000);
    n_cmp++; if ({iss_valid, rob_count, rob_head_tag} !== 8'b0)
      begin n_bad++; $display("FAIL flush_state: got v=%b cnt=%0d head=%0d want 0/0/0", iss_valid, rob_count, rob_head_tag); end
    step(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 3'b000);
    n_cmp++; if ({rob_count, rob_head_tag} !== 7'b0) begin n_bad++; $display("FAIL flush_empty_commit: got cnt=%0d head=%0d want 0/0", rob_count, rob_head_tag); end
    step(1'b1, 4'h8, 4'h1, 4'h2, 4'h9, 1'b0, 3'b000);
    n_cmp++; if ({iss_valid, iss_tag, iss_rs1_busy, iss_rs2_busy} !== 6'b1_000_0_0)
      begin n_bad++; $display("FAIL flush_rat: got v=%b tag=%0d b1=%b b2=%b want 1/0/0/0", iss_valid, iss_tag, iss_rs1_busy, iss_rs2_busy); end
    step(1'b1, 4'h9, 4'h0, 4'h0, 4'hA, 1'b0, 3'b000);
    step(1'b1, 4'hA, 4'h0, 4'h0, 4'hB, 1'b0, 3'b000);
    n_cmp++; if ({iss_valid, iss_tag, rob_count} !== 8'b1_010_0011)
      begin n_bad++; $display("FAIL flush_rs_cleared: got v=%b tag=%0d cnt=%0d want 1/2/3", iss_valid, iss_tag, rob_count); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_fill();
    test_rob_wrap();
    test_rs_full();
    test_rat_commit();
    test_same_rd();
    test_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
